// File: rtl/data_mem_seq_if.sv
// Word-organised data memory bus with a req/ack handshake.
// The sequencer drives the master side; the memory drives the slave side.
interface data_mem_seq_if;
    logic        MemReq;
    logic [29:0] MemAddr;
    logic [3:0]  MemWe;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq,
        output MemAddr,
        output MemWe,
        output MemWData,
        input  MemAck,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemAddr,
        input  MemWe,
        input  MemWData,
        output MemAck,
        output MemRData
    );
endinterface

// File: rtl/data_mem_seq.sv
// MEM-stage load/store sequencer: splits unaligned accesses into two word
// accesses, builds byte enables / lane-aligned data and extends load results.
module data_mem_seq (
    input  logic                 CPU_CLK,
    input  logic                 CPU_RST,
    input  logic                 ReqValid,
    input  logic                 ReqWrite,
    input  logic [2:0]           ReqType,
    input  logic [31:0]          ReqAddr,
    input  logic [31:0]          ReqWData,
    output logic                 Stall,
    output logic                 RespValid,
    output logic [31:0]          RespData,
    data_mem_seq_if.master       mem
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  off_q;
    logic [2:0]  type_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] lo;
    logic [31:0] hi;

    // Access size in bytes; 0 for the no-access encodings.
    function automatic logic [2:0] size_of(input logic [2:0] t);
        case (t)
            3'd1, 3'd4: size_of = 3'd1;
            3'd2, 3'd5: size_of = 3'd2;
            3'd3:       size_of = 3'd4;
            default:    size_of = 3'd0;
        endcase
    endfunction

    // Byte enables across the two-word window starting at the first word.
    function automatic logic [7:0] be_of(input logic [2:0] t, input logic [1:0] off);
        logic [7:0] mask;
        case (size_of(t))
            3'd1:    mask = 8'h01;
            3'd2:    mask = 8'h03;
            3'd4:    mask = 8'h0F;
            default: mask = 8'h00;
        endcase
        be_of = mask << off;
    endfunction

    logic        req_ok;
    logic [7:0]  req_be;
    logic [7:0]  q_be;
    logic        q_split;
    logic [5:0]  hi_shift;
    logic [63:0] rd_window;

    assign req_ok   = ReqValid && (ReqType inside {[3'd1:3'd5]});
    assign req_be   = be_of(ReqType, ReqAddr[1:0]);
    assign q_be     = be_of(type_q, off_q);
    assign q_split  = ({2'b00, off_q} + {1'b0, size_of(type_q)}) > 4'd4;
    // Second-word store data: bytes that did not fit in the first word.
    assign hi_shift = 6'd32 - {1'b0, off_q, 3'b000};

    always_ff @(posedge CPU_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (CPU_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (req_ok) state_nxt = ACC0;
            ACC0:    if (mem.MemAck) state_nxt = q_split ? ACC1 : DONE;
            ACC1:    if (mem.MemAck) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, memory-side registers and read-word capture.
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            off_q        <= '0;
            type_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            lo           <= '0;
            hi           <= '0;
            mem.MemReq   <= 1'b0;
            mem.MemAddr  <= '0;
            mem.MemWe    <= '0;
            mem.MemWData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        off_q        <= ReqAddr[1:0];
                        type_q       <= ReqType;
                        write_q      <= ReqWrite;
                        wdata_q      <= ReqWData;
                        mem.MemReq   <= 1'b1;
                        mem.MemAddr  <= ReqAddr[31:2];
                        mem.MemWe    <= ReqWrite ? req_be[3:0] : 4'b0000;
                        mem.MemWData <= ReqWData << {ReqAddr[1:0], 3'b000};
                    end
                end
                ACC0: begin
                    if (mem.MemAck) begin
                        lo <= mem.MemRData;
                        if (q_split) begin
                            mem.MemAddr  <= mem.MemAddr + 30'd1;
                            mem.MemWe    <= write_q ? q_be[7:4] : 4'b0000;
                            mem.MemWData <= wdata_q >> hi_shift;
                        end else begin
                            mem.MemReq <= 1'b0;
                            mem.MemWe  <= 4'b0000;
                        end
                    end
                end
                ACC1: begin
                    if (mem.MemAck) begin
                        hi         <= mem.MemRData;
                        mem.MemReq <= 1'b0;
                        mem.MemWe  <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_window = {hi, lo} >> {off_q, 3'b000};

    always_comb begin
        Stall     = (state == IDLE && req_ok) || state == ACC0 || state == ACC1;
        RespValid = (state == DONE);
        RespData  = '0;
        if (state == DONE && !write_q) begin
            case (type_q)
                3'd1:    RespData = {{24{rd_window[7]}}, rd_window[7:0]};
                3'd2:    RespData = {{16{rd_window[15]}}, rd_window[15:0]};
                3'd3:    RespData = rd_window[31:0];
                3'd4:    RespData = {24'h0, rd_window[7:0]};
                3'd5:    RespData = {16'h0, rd_window[15:0]};
                default: RespData = '0;
            endcase
        end
    end

    // While a request waits for ack, the memory must see a frozen request.
    assert property (@(posedge CPU_CLK) disable iff (CPU_RST)
        (mem.MemReq && !mem.MemAck) |=> (mem.MemReq && $stable(mem.MemAddr) &&
                                         $stable(mem.MemWe) && $stable(mem.MemWData)));

endmodule

// File: tb/tb_data_mem_seq.sv
// Scoreboard bench for data_mem_seq: directed loads/stores against a
// variable-latency memory model; responses and memory accesses checked from queues.
module tb_data_mem_seq;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST;
    logic        ReqValid;
    logic        ReqWrite;
    logic [2:0]  ReqType;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        Stall;
    logic        RespValid;
    logic [31:0] RespData;

    data_mem_seq_if mif ();

    data_mem_seq dut (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST   (CPU_RST),
        .ReqValid  (ReqValid),
        .ReqWrite  (ReqWrite),
        .ReqType   (ReqType),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .Stall     (Stall),
        .RespValid (RespValid),
        .RespData  (RespData),
        .mem       (mif)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_resp[$];
    logic [31:0] mem_words [logic [29:0]];
    int          ack_delay;
    int          wait_cnt;
    logic        force_ack;
    int          pass_cnt;
    int          total_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        return mem_words.exists(a) ? mem_words[a] : 32'h0;
    endfunction

    task automatic push_acc(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd);
        acc_t e;
        e.addr = a;
        e.we = we;
        e.wdata = wd;
        exp_acc.push_back(e);
    endtask

    // Issue one request and hold it until DONE; lat = negedges from issue to RespValid.
    task automatic issue(input string name, input logic wr, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int lat, input logic [31:0] exp_data);
        int n;
        bit got;
        @(negedge CPU_CLK);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqType  = typ;
        ReqAddr  = addr;
        ReqWData = wd;
        exp_resp.push_back(wr ? 32'h0 : exp_data);
        #1 check({name, "_stall_issue"}, Stall, 1'b1);
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            @(negedge CPU_CLK);
            n++;
            if (RespValid) got = 1;
            else check({name, "_stall_held"}, Stall, 1'b1);
        end
        if (!got) begin
            check({name, "_timeout"}, RespValid, 1'b1);
        end else begin
            check({name, "_latency"}, n, lat);
            check({name, "_stall_done"}, Stall, 1'b0);
        end
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqType  = 3'd0;
        ReqWData = 32'h0;
    endtask

    task automatic stimulus();
        // LW aligned, split and non-split sub-word loads.
        push_acc(30'h400, 4'h0, 32'h0);
        issue("lw_1000", 1'b0, 3'd3, 32'h1000, 32'h0, 2, 32'h8899AABB);
        push_acc(30'h400, 4'h0, 32'h0);
        push_acc(30'h401, 4'h0, 32'h0);
        issue("lh_1003", 1'b0, 3'd2, 32'h1003, 32'h0, 3, 32'h00004488);
        push_acc(30'h400, 4'h0, 32'h0);
        issue("lb_1003", 1'b0, 3'd1, 32'h1003, 32'h0, 2, 32'hFFFFFF88);
        push_acc(30'h400, 4'h0, 32'h0);
        issue("lbu_1003", 1'b0, 3'd4, 32'h1003, 32'h0, 2, 32'h00000088);
        push_acc(30'h400, 4'h0, 32'h0);
        push_acc(30'h401, 4'h0, 32'h0);
        issue("lw_1002", 1'b0, 3'd3, 32'h1002, 32'h0, 3, 32'h33448899);
        push_acc(30'h400, 4'h0, 32'h0);
        issue("lhu_1001", 1'b0, 3'd5, 32'h1001, 32'h0, 2, 32'h000099AA);

        // Split LW with three cycles of ack delay on each access.
        ack_delay = 3;
        push_acc(30'h400, 4'h0, 32'h0);
        push_acc(30'h401, 4'h0, 32'h0);
        issue("lw_slow", 1'b0, 3'd3, 32'h1002, 32'h0, 9, 32'h33448899);

        // Same access, reset while waiting in ACC1: no response may follow.
        push_acc(30'h400, 4'h0, 32'h0);
        push_acc(30'h401, 4'h0, 32'h0);
        @(negedge CPU_CLK);
        ReqValid = 1'b1;
        ReqType  = 3'd3;
        ReqAddr  = 32'h1002;
        repeat (6) @(negedge CPU_CLK);
        check("rst_acc1_addr", mif.MemAddr, 30'h401);
        check("rst_acc1_stall", Stall, 1'b1);
        CPU_RST = 1'b1;
        @(negedge CPU_CLK);
        check("rst_memreq", mif.MemReq, 1'b0);
        check("rst_stall_req1", Stall, ReqValid);
        exp_acc.delete();
        ack_delay = 0;
        ReqValid = 1'b0;
        CPU_RST  = 1'b0;
        #1 check("rst_stall_req0", Stall, ReqValid);
        force_ack = 1'b1;
        repeat (2) @(negedge CPU_CLK);
        force_ack = 1'b0;
        repeat (3) begin
            @(negedge CPU_CLK);
            check("stray_ack_memreq", mif.MemReq, 1'b0);
            check("stray_ack_resp", RespValid, 1'b0);
        end

        // Split store, then read it back.
        push_acc(30'h400, 4'b1110, 32'hADBEEF00);
        push_acc(30'h401, 4'b0001, 32'h000000DE);
        issue("sw_1001", 1'b1, 3'd3, 32'h1001, 32'hDEADBEEF, 3, 32'h0);
        check("sw_mem400", rd_word(30'h400), 32'hADBEEFBB);
        check("sw_mem401", rd_word(30'h401), 32'h112233DE);
        push_acc(30'h400, 4'h0, 32'h0);
        push_acc(30'h401, 4'h0, 32'h0);
        issue("lw_1001", 1'b0, 3'd3, 32'h1001, 32'h0, 3, 32'hDEADBEEF);

        // Byte store into lane 2, then a sign-extending halfword load over it.
        push_acc(30'h400, 4'b0100, 32'h56770000);
        issue("sb_1002", 1'b1, 3'd1, 32'h1002, 32'h12345677, 2, 32'h0);
        push_acc(30'h400, 4'h0, 32'h0);
        issue("lh_1002", 1'b0, 3'd2, 32'h1002, 32'h0, 2, 32'hFFFFAD77);

        // Word address wraps at the top of the address space.
        push_acc(30'h3FFFFFFF, 4'h0, 32'h0);
        push_acc(30'h0, 4'h0, 32'h0);
        issue("lw_wrap", 1'b0, 3'd3, 32'hFFFFFFFE, 32'h0, 3, 32'h0304CAFE);

        // No-access encodings.
        for (int t = 0; t < 2; t++) begin
            @(negedge CPU_CLK);
            ReqValid = 1'b1;
            ReqType  = (t == 0) ? 3'd0 : 3'd7;
            ReqAddr  = 32'h1000;
            #1 check("noacc_stall", Stall, 1'b0);
            repeat (2) begin
                @(negedge CPU_CLK);
                check("noacc_memreq", mif.MemReq, 1'b0);
            end
        end
        ReqValid = 1'b0;
        ReqType  = 3'd0;

        repeat (3) @(negedge CPU_CLK);
        check("acc_queue_empty", exp_acc.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);
    endtask

    initial begin
        CPU_RST   = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqType   = 3'd0;
        ReqAddr   = 32'h0;
        ReqWData  = 32'h0;
        mif.MemAck   = 1'b0;
        mif.MemRData = 32'h0;
        ack_delay = 0;
        wait_cnt  = 0;
        force_ack = 1'b0;
        pass_cnt  = 0;
        total_cnt = 0;
        mem_words[30'h400]      = 32'h8899AABB;
        mem_words[30'h401]      = 32'h11223344;
        mem_words[30'h3FFFFFFF] = 32'hCAFEF00D;
        mem_words[30'h0]        = 32'h01020304;

        repeat (2) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        check("reset_memreq", mif.MemReq, 1'b0);
        check("reset_memaddr", mif.MemAddr, 30'h0);
        check("reset_memwe", mif.MemWe, 4'h0);
        check("reset_memwdata", mif.MemWData, 32'h0);
        check("reset_respvalid", RespValid, 1'b0);
        check("reset_respdata", RespData, 32'h0);
        check("reset_stall", Stall, 1'b0);
        CPU_RST = 1'b0;

        fork
            // Memory model: acks after ack_delay cycles, checks each request.
            forever begin
                @(negedge CPU_CLK);
                if (force_ack) begin
                    mif.MemAck = 1'b1;
                end else if (mif.MemReq) begin
                    if (exp_acc.size() == 0) begin
                        check("mem_unexpected_req", mif.MemReq, 1'b0);
                        mif.MemAck = 1'b0;
                    end else if (wait_cnt < ack_delay) begin
                        check("mem_hold_addr", mif.MemAddr, exp_acc[0].addr);
                        check("mem_hold_we", mif.MemWe, exp_acc[0].we);
                        wait_cnt++;
                        mif.MemAck = 1'b0;
                    end else begin
                        acc_t e;
                        logic [31:0] w;
                        e = exp_acc.pop_front();
                        check("mem_addr", mif.MemAddr, e.addr);
                        check("mem_we", mif.MemWe, e.we);
                        check("mem_wdata", mif.MemWData, e.wdata);
                        w = rd_word(mif.MemAddr);
                        mif.MemRData = w;
                        for (int b = 0; b < 4; b++)
                            if (mif.MemWe[b]) w[8*b +: 8] = mif.MemWData[8*b +: 8];
                        mem_words[mif.MemAddr] = w;
                        mif.MemAck = 1'b1;
                        wait_cnt = 0;
                    end
                end else begin
                    mif.MemAck = 1'b0;
                    wait_cnt = 0;
                end
            end
            // Response monitor.
            forever begin
                @(negedge CPU_CLK);
                if (RespValid) begin
                    if (exp_resp.size() == 0) check("resp_unexpected", RespValid, 1'b0);
                    else check("resp_data", RespData, exp_resp.pop_front());
                end
            end
            stimulus();
        join_any
        disable fork;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_seq.md
Name: data_mem_seq

Overview:
Sequencer between the MEM-stage load/store request and a variable-latency, word-organised data memory with a req/ack handshake. It splits any access that crosses a 32-bit word boundary into two aligned word accesses. It generates byte enables and shifted write data, merges read words, and sign- or zero-extends load results. It stalls the pipeline until the access completes.

Parameters:
None. All widths are fixed: 32-bit byte address and 30-bit word address.

Ports:
CPU_CLK    in   1   clock; all state updates on the rising edge
CPU_RST    in   1   synchronous, active-high reset
ReqValid   in   1   MEM-stage access request; held by the pipeline while Stall=1
ReqWrite   in   1   1=store, 0=load
ReqType    in   3   1=byte(LB/SB), 2=half(LH/SH), 3=word(LW/SW), 4=LBU, 5=LHU; 0,6,7=no access
ReqAddr    in   32  byte address
ReqWData   in   32  store data, right-aligned
Stall      out  1   freeze pipeline (combinational)
RespValid  out  1   one-cycle pulse: access complete
RespData   out  32  extended load result; 0 for stores
MemReq     out  1   memory request, held until MemAck
MemAddr    out  30  word address
MemWe      out  4   byte write enables; 0 for loads
MemWData   out  32  lane-aligned write data
MemAck     in   1   memory accepts the request; MemRData valid in the same cycle
MemRData   in   32  read word, little-endian lanes

Behaviour:
- Derived values:
  - size: 1, 2 or 4 bytes from ReqType.
  - off = ReqAddr[1:0].
  - split = (off + size > 4).
  - mask = (1<<size)-1.
  - be = mask << off, an 8-bit value.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - If ReqValid and ReqType is in 1..5, latch addr/type/write/wdata and go to ACC0.
  - On that transition: MemReq<=1, MemAddr<=ReqAddr[31:2], MemWe<=ReqWrite ? be[3:0] : 0, MemWData<=ReqWData<<(8*off).
  - Otherwise stay in IDLE.
- ACC0, while MemAck=0:
  - Hold all memory outputs.
- ACC0, on MemAck=1:
  - Capture lo<=MemRData.
  - If split: go to ACC1. Set MemAddr<=MemAddr+1 (30-bit wrap, so 0x3FFFFFFF→0), MemWe<=write ? be[7:4] : 0, MemWData<=wdata>>(8*(4-off)), MemReq stays 1.
  - Else: go to DONE with MemReq<=0, MemWe<=0.
- ACC1, on MemAck=1:
  - Capture hi<=MemRData.
  - Go to DONE with MemReq<=0, MemWe<=0.
- DONE:
  - RespValid=1.
  - RespData = write ? 0 : ext(({hi,lo} >> (8*off))[size*8-1:0]). Extension is sign for types 1/2, zero for 4/5, none for 3.
  - Return to IDLE unconditionally.
- Stall = (state==IDLE && ReqValid && ReqType∈1..5) || state==ACC0 || state==ACC1. Stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency:
  - Non-split access with immediate ack: 3 cycles (IDLE, ACC0, DONE).
  - Split access: +1 cycle.
  - Each cycle of ack delay adds one cycle.
- Request inputs are sampled only in IDLE; changes during ACC0/ACC1/DONE are ignored.
- MemAck in IDLE or DONE is ignored.
- The memory must never see MemReq=1 with MemWe changing before ack.
- Reset values: state=IDLE, MemReq=0, MemAddr=0, MemWe=0, MemWData=0, lo=hi=0, RespValid=0, RespData=0.
- Reset mid-operation (any state):
  - Go to IDLE and drop MemReq at that edge.
  - No RespValid is issued.
  - A later stray MemAck is ignored.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately following DONE.

Test Plan:
Memory preset: word 0x400 (byte 0x1000) = 0x8899AABB, word 0x401 = 0x11223344. Ack is immediate unless stated.

- LW at 0x1000 → one MemReq at MemAddr 0x400, MemWe 0. RespValid in the 3rd cycle with RespData 0x8899AABB. Stall high for cycles 1–2.
- LH at 0x1003 → two accesses (0x400 then 0x401), RespData 0x00004488. LB at 0x1003 → 0xFFFFFF88. LBU at 0x1003 → 0x00000088.
- LW at 0x1002 → split access, RespData 0x33448899. LHU at 0x1001 → single access, RespData 0x000099AA.
- SW at 0x1001 with data 0xDEADBEEF:
  - Access 1: MemAddr 0x400, MemWe 4'b1110, MemWData 0xADBEEF00.
  - Access 2: MemAddr 0x401, MemWe 4'b0001, MemWData 0x000000DE.
  - RespData 0.
- MemAck delayed 3 cycles on each access of a split LW → MemReq, MemAddr and Stall are held steady; RespValid arrives 6 cycles after the non-delayed timing. In a second run, assert CPU_RST during ACC1 → next cycle MemReq=0, Stall follows ReqValid only, and no RespValid is issued.
- Corner cases:
  - ReqValid with ReqType=0 or 7 → no MemReq, Stall=0.
  - LW at 0xFFFFFFFE → second access MemAddr 0x00000000.
